// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg, then echoes every received byte back
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'h0515,
  parameter logic [15:0] DIV_9600  = 16'h028A,
  parameter logic [15:0] DIV_19200 = 16'h0144,
  parameter logic [15:0] DIV_38400 = 16'h00A2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  output logic [7:0]  rx_byte,
  output logic [15:0] echo_count,
  output logic        cfg_done
);
  typedef enum logic [2:0] {INIT, CFG_LO, CFG_HI, POLL_RX, READ_RX, POLL_TX, WRITE_TX} state_t;
  state_t      state_q, state_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [15:0] echo_count_q, echo_count_d;
  logic        cfg_done_q, cfg_done_d;
  logic [1:0]  br_cfg_q, br_cfg_d;
  logic [15:0] div;
  logic [7:0]  dout;
  logic        cfg_changed;
  assign div = br_cfg == 2'b00 ? DIV_4800 :
               br_cfg == 2'b01 ? DIV_9600 :
               br_cfg == 2'b10 ? DIV_19200 : DIV_38400;
  assign cfg_changed = br_cfg != br_cfg_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  // a baud change is only honoured while idle-polling, so an accepted byte is always echoed
  always_comb begin
    state_d = INIT;
    case (state_q)
      INIT:     state_d = CFG_LO;
      CFG_LO:   state_d = CFG_HI;
      CFG_HI:   state_d = POLL_RX;
      POLL_RX:  state_d = cfg_changed ? CFG_LO : databus[0] ? READ_RX : POLL_RX;
      READ_RX:  state_d = POLL_TX;
      POLL_TX:  state_d = databus[1] ? WRITE_TX : POLL_TX;
      WRITE_TX: state_d = POLL_RX;
      default:  state_d = INIT;
    endcase
  end
  always_comb begin
    iocs   = state_q != INIT;
    iorw   = state_q inside {POLL_RX, READ_RX, POLL_TX};
    ioaddr = state_q == CFG_LO ? 2'b10 :
             state_q == CFG_HI ? 2'b11 :
             state_q inside {POLL_RX, POLL_TX} ? 2'b01 : 2'b00;
    dout   = state_q == CFG_LO ? div[7:0] :
             state_q == CFG_HI ? div[15:8] : rx_byte_q;
  end
  assign databus = (iocs && !iorw) ? dout : 8'bz;
  always_comb begin
    rx_byte_d    = state_q == READ_RX ? databus : rx_byte_q;
    echo_count_d = state_q == WRITE_TX ? echo_count_q + 16'd1 : echo_count_q;
    cfg_done_d   = state_q == CFG_HI ? 1'b1 :
                   (state_q == POLL_RX && cfg_changed) ? 1'b0 : cfg_done_q;
    br_cfg_d     = state_q == CFG_HI ? br_cfg : br_cfg_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_byte_q    <= 8'h00;
      echo_count_q <= 16'h0000;
      cfg_done_q   <= 1'b0;
      br_cfg_q     <= 2'b00;
    end else begin
      rx_byte_q    <= rx_byte_d;
      echo_count_q <= echo_count_d;
      cfg_done_q   <= cfg_done_d;
      br_cfg_q     <= br_cfg_d;
    end
  assign rx_byte    = rx_byte_q;
  assign echo_count = echo_count_q;
  assign cfg_done   = cfg_done_q;
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: SPART bus model with a transaction-level scoreboard, directed scenarios, then random traffic
module tb_spart_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  br_cfg = 2'b01;
  logic        iocs, iorw, cfg_done;
  logic [1:0]  ioaddr;
  logic [7:0]  rx_byte;
  logic [15:0] echo_count;
  wire  [7:0]  databus;
  logic        rda = 1'b0, tbr = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  spart_dout;
  int          errors = 0, checks = 0;
  logic [15:0] exp_echo = 16'h0;
  logic [7:0]  exp_rx = 8'h0;
  logic        exp_cfg = 1'b0, pending = 1'b0, prev_rda = 1'b0, prev_tbr = 1'b0;
  logic [3:0]  last_op;
  logic [7:0]  last_data;
  logic [15:0] d;

  assign spart_dout = ioaddr == 2'b01 ? {6'b0, tbr, rda} : rx_data;
  assign databus = (iocs && iorw) ? spart_dout : 8'bz;
  always #5 clk = ~clk;

  spart_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rx_byte(rx_byte), .echo_count(echo_count), .cfg_done(cfg_done)
  );

  function automatic logic [15:0] div_of(input logic [1:0] c);
    return c == 2'b00 ? 16'h0515 : c == 2'b01 ? 16'h028A : c == 2'b10 ? 16'h0144 : 16'h00A2;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // observe one bus cycle mid-cycle, score it, then advance to just after the next edge
  task automatic cycle();
    #1;
    check("echo_count", echo_count, exp_echo);
    check("rx_byte", 16'(rx_byte), 16'(exp_rx));
    check("cfg_done", 16'(cfg_done), 16'((iocs && !iorw && ioaddr[1]) ? 1'b0 : exp_cfg));
    last_op = {iocs, iorw, ioaddr};
    last_data = databus;
    d = div_of(br_cfg);
    if (iocs && iorw) begin
      check("rd_data", 16'(databus), 16'(spart_dout));
      if (ioaddr == 2'b00) begin
        check("rd_after_rda", 16'(prev_rda), 16'd1);
        exp_rx = databus;
        pending = 1'b1;
      end
    end else if (iocs) begin
      check("wr_addr", 16'(ioaddr != 2'b01), 16'd1);
      if (ioaddr == 2'b10) begin
        check("div_lo", 16'(databus), 16'(d[7:0]));
        check("no_drop", 16'(pending), 16'd0);
        exp_cfg = 1'b0;
      end
      if (ioaddr == 2'b11) begin
        check("div_hi", 16'(databus), 16'(d[15:8]));
        exp_cfg = 1'b1;
      end
      if (ioaddr == 2'b00) begin
        check("echo_data", 16'(databus), 16'(exp_rx));
        check("wr_after_tbr", 16'(prev_tbr), 16'd1);
        pending = 1'b0;
        exp_echo++;
      end
    end else check("idle_bus", 16'({iorw, ioaddr}), 16'd0);
    prev_rda = iocs && iorw && ioaddr == 2'b01 && databus[0];
    prev_tbr = iocs && iorw && ioaddr == 2'b01 && databus[1];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_bus", 16'({iocs, iorw, ioaddr}), 16'd0);
    check("rst_echo", echo_count, 16'd0);
    check("rst_rx", 16'(rx_byte), 16'd0);
    check("rst_cfg", 16'(cfg_done), 16'd0);
    exp_echo = 16'h0; exp_rx = 8'h0; exp_cfg = 1'b0;
    pending = 1'b0; prev_rda = 1'b0; prev_tbr = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    #3;
    do_reset();
    cycle(); check("t1_init", 16'(last_op), 16'h0);
    cycle(); check("t1_lo", 16'({last_op, last_data}), 16'hA8A);
    cycle(); check("t1_hi", 16'({last_op, last_data}), 16'hB02);
    check("t1_first_poll", 16'({iocs, iorw, ioaddr}), 16'hD);
    check("t1_cfg_done", 16'(cfg_done), 16'd1);

    for (int i = 0; i < 10; i++) begin
      cycle(); check("t2_poll", 16'(last_op), 16'hD);
    end
    rx_data = 8'h41; rda = 1'b1; tbr = 1'b1;
    cycle();
    cycle(); check("t2_read", 16'({last_op, last_data}), 16'hC41);
    cycle();
    cycle(); check("t2_write", 16'({last_op, last_data}), 16'h841);
    check("t2_echo", echo_count, 16'd1);

    rx_data = 8'h5C; rda = 1'b1; tbr = 1'b0;
    cycle();
    cycle(); check("t3_read", 16'({last_op, last_data}), 16'hC5C);
    rda = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(); check("t3_hold", 16'(last_op), 16'hD);
    end
    tbr = 1'b1;
    cycle(); check("t3_tbr_poll", 16'(last_op), 16'hD);
    cycle(); check("t3_write", 16'({last_op, last_data}), 16'h85C);

    rx_data = 8'h77; rda = 1'b1; tbr = 1'b0;
    cycle();
    cycle(); check("t4_read", 16'({last_op, last_data}), 16'hC77);
    br_cfg = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("t4_hold", 16'(last_op), 16'hD);
    end
    tbr = 1'b1;
    cycle();
    cycle(); check("t4_write", 16'({last_op, last_data}), 16'h877);
    cycle(); check("t4_poll", 16'(last_op), 16'hD);
    cycle(); check("t4_lo", 16'({last_op, last_data}), 16'hAA2);
    check("t4_cfg_low", 16'(cfg_done), 16'd0);
    cycle(); check("t4_hi", 16'({last_op, last_data}), 16'hB00);
    check("t4_cfg_done", 16'(cfg_done), 16'd1);

    rda = 1'b1; tbr = 1'b1; rx_data = 8'h3E;
    n = 0;
    while (!(iocs && !iorw && ioaddr == 2'b00) && n < 8) begin
      cycle();
      n++;
    end
    check("t5_in_write", 16'({iocs, iorw, ioaddr}), 16'h8);
    do_reset();
    cycle(); check("t5_init", 16'(last_op), 16'h0);
    cycle(); check("t5_lo", 16'({last_op, last_data}), 16'hAA2);
    cycle(); check("t5_hi", 16'({last_op, last_data}), 16'hB00);

    rda = 1'b0; tbr = 1'b0;
    cycle();
    force dut.echo_count_q = 16'hFFFF;
    #1;
    release dut.echo_count_q;
    exp_echo = 16'hFFFF;
    rda = 1'b1; tbr = 1'b1; rx_data = 8'hC3;
    for (int i = 0; i < 4; i++) cycle();
    check("t6_wrap", echo_count, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      rda = $urandom_range(0, 2) == 0;
      tbr = $urandom_range(0, 2) == 0;
      rx_data = 8'($urandom);
      if ($urandom_range(0, 49) == 0) br_cfg = 2'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
